// File: rtl/game_controller.sv
// Memory-sequence game FSM: LFSR-generated color sequence, LED playback, timed button input, scoring.
// Latency: accepted START to first LED lit is 2 cycles (ADD, SHOW_ON); LED/WIN/LOSE decode straight from state.
// Backpressure: none; START/BTN/TICK are single-cycle strobes, BTN is ignored outside INPUT.
module game_controller #(
    parameter int          MAX_ROUND     = 15,
    parameter int          SHOW_TICKS    = 2,
    parameter int          TIMEOUT_TICKS = 20,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] SETUP_LEVEL,
    input  logic [1:0] SETUP_MAPA,
    input  logic [3:0] BTN,
    input  logic       TICK,
    output logic [3:0] LED,
    output logic [3:0] ROUND,
    output logic [7:0] POINTS,
    output logic [2:0] STATE,
    output logic       WIN,
    output logic       LOSE
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADD      = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_INPUT    = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;
    localparam logic [2:0] S_WIN      = 3'd6;
    localparam logic [2:0] S_LOSE     = 3'd7;

    localparam logic [7:0] SHOW_LAST    = 8'(SHOW_TICKS - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);
    localparam logic [3:0] FINAL_ROUND  = 4'(MAX_ROUND);

    logic [2:0] state;
    logic [7:0] lfsr;
    logic [1:0] mem [16];
    logic [3:0] round_q;
    logic [3:0] idx;
    logic [7:0] show_cnt;
    logic [7:0] to_cnt;
    logic [1:0] level;
    logic [7:0] points_q;

    logic       lfsr_fb;
    logic       start_ok;
    logic       last_idx;
    logic [3:0] cur_hot;

    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign start_ok = START && (SETUP_LEVEL != 2'd0);
    assign last_idx = (idx == (round_q - 4'd1));
    assign cur_hot  = 4'b0001 << mem[idx];

    // Sequence memory has no reset: every entry is written in ADD before any read of it.
    always_ff @(posedge CLOCK) begin
        if (RESET && (state == S_ADD)) begin
            mem[round_q] <= lfsr[1:0];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state    <= S_IDLE;
            lfsr     <= LFSR_SEED;
            round_q  <= 4'd0;
            idx      <= 4'd0;
            show_cnt <= 8'd0;
            to_cnt   <= 8'd0;
            level    <= 2'd0;
            points_q <= 8'd0;
        end else begin
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start_ok) begin
                        level    <= SETUP_LEVEL;
                        lfsr     <= LFSR_SEED ^ {SETUP_MAPA, 6'b0};
                        round_q  <= 4'd0;
                        points_q <= 8'd0;
                        idx      <= 4'd0;
                        show_cnt <= 8'd0;
                        to_cnt   <= 8'd0;
                        state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    lfsr     <= {lfsr[6:0], lfsr_fb};
                    round_q  <= round_q + 4'd1;
                    idx      <= 4'd0;
                    show_cnt <= 8'd0;
                    state    <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (TICK) begin
                        if (show_cnt == SHOW_LAST) begin
                            show_cnt <= 8'd0;
                            state    <= S_SHOW_OFF;
                        end else begin
                            show_cnt <= show_cnt + 8'd1;
                        end
                    end
                end
                S_SHOW_OFF: begin
                    if (TICK) begin
                        if (last_idx) begin
                            idx    <= 4'd0;
                            to_cnt <= 8'd0;
                            state  <= S_INPUT;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= S_SHOW_ON;
                        end
                    end
                end
                S_INPUT: begin
                    // A press wins over a coincident TICK, so it can never time out.
                    if (BTN != 4'd0) begin
                        to_cnt <= 8'd0;
                        if (BTN == cur_hot) begin
                            if (last_idx) begin
                                state <= S_NEXT;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end else begin
                            state <= S_LOSE;
                        end
                    end else if (TICK) begin
                        if (to_cnt == TIMEOUT_LAST) begin
                            state <= S_LOSE;
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end
                end
                S_NEXT: begin
                    points_q <= {6'd0, level} * {4'd0, round_q};
                    state    <= (round_q == FINAL_ROUND) ? S_WIN : S_ADD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        LED = 4'd0;
        if (state == S_SHOW_ON) begin
            LED = cur_hot;
        end
    end

    assign STATE  = state;
    assign ROUND  = round_q;
    assign POINTS = points_q;
    assign WIN    = (state == S_WIN);
    assign LOSE   = (state == S_LOSE);

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter MAX_ROUND, default 15: final round; reaching it gives a win (1..15).
REQ-002 SHALL have parameter SHOW_TICKS, default 2: TICK strobes each LED stays lit during playback.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 20: TICK strobes allowed per press in INPUT.
REQ-004 SHALL have parameter LFSR_SEED, default 8'hA5: base seed of the color generator.
REQ-005 SHALL have port CLOCK, input, 1: single clock, all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port START, input, 1: single-cycle pulse that starts a game.
REQ-008 SHALL have port SETUP_LEVEL, input, 2: difficulty 1..3; 0 is invalid.
REQ-009 SHALL have port SETUP_MAPA, input, 2: color-map select, mixed into the seed.
REQ-010 SHALL have port BTN, input, 4: player buttons, debounced upstream, single-cycle pulses.
REQ-011 SHALL have port TICK, input, 1: one-cycle timing strobe.
REQ-012 SHALL have port LED, output, 4: one-hot color shown, or 0.
REQ-013 SHALL have port ROUND, output, 4: current round number.
REQ-014 SHALL have port POINTS, output, 8: registered score.
REQ-015 SHALL have port STATE, output, 3: FSM state code.
REQ-016 SHALL have ports WIN and LOSE, output, 1 each: end-of-game flags.

Function
REQ-017 SHALL use these states and codes: IDLE=0, ADD=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, NEXT=5, WIN=6, LOSE=7.
REQ-018 SHALL handle START in IDLE, WIN and LOSE as follows: if SETUP_LEVEL!=0, latch SETUP_LEVEL, load LFSR = LFSR_SEED ^ {SETUP_MAPA,6'b0}, clear ROUND, POINTS, WIN and LOSE, and go to ADD; if SETUP_LEVEL==0, ignore START.
REQ-019 SHALL ignore START in states 1..5.
REQ-020 SHALL, in ADD (one cycle): write mem[ROUND] = LFSR[1:0] into the 16x2 sequence memory; shift LFSR left with new bit0 = b7^b5^b4^b3; increment ROUND; clear index idx; go to SHOW_ON.
REQ-021 SHALL, in SHOW_ON: drive LED = 1<<mem[idx]; after SHOW_TICKS TICK strobes, go to SHOW_OFF.
REQ-022 SHALL, in SHOW_OFF: drive LED=0 for 1 TICK, then go to INPUT with idx=0 if idx==ROUND-1, otherwise increment idx and go to SHOW_ON.
REQ-023 SHALL drive LED=0 in all states other than SHOW_ON.
REQ-024 SHALL treat a BTN pulse in INPUT as nonzero BTN for one cycle; BTN equal to 1<<mem[idx] is correct; any other nonzero value, including multi-hot, is wrong and goes to LOSE.
REQ-025 SHALL, on a correct press, go to NEXT if idx==ROUND-1, otherwise increment idx and stay in INPUT.
REQ-026 SHALL count TICK strobes in INPUT, clear the count on every press, and go to LOSE when the count reaches TIMEOUT_TICKS.
REQ-027 SHALL give BTN priority when BTN and TICK arrive in the same cycle: the press is evaluated, the count is cleared, and no timeout occurs.
REQ-028 SHALL ignore BTN outside INPUT.
REQ-029 SHALL, in NEXT (one cycle): set POINTS <= level*ROUND as an 8-bit product (maximum 3*15=45, no overflow); go to WIN if ROUND==MAX_ROUND, otherwise go to ADD.
REQ-030 SHALL hold WIN=1 in WIN and LOSE=1 in LOSE; ROUND and POINTS hold until the next accepted START.
REQ-031 SHALL give latency from accepted START to first LED lit of 2 cycles (ADD, then SHOW_ON).
REQ-032 SHALL drive the STATE output directly from the state register.

Reset
REQ-033 SHALL, while RESET==0 at a rising edge: STATE=IDLE, LED=0, ROUND=0, POINTS=0, WIN=0, LOSE=0, LFSR=LFSR_SEED, idx=0, counters=0, latched level=0.
REQ-034 SHALL abort any state mid-game on reset, with no residual output on the next cycle.
REQ-035 SHALL not require the sequence memory to be reset; it is always written before it is read.

Verification
REQ-036 SHALL cover: level=2, MAPA=0, START -> ADD, then SHOW_ON with LED=4'b0010 (color 01 from 8'hA5) lit for 2 TICKs, then INPUT.
REQ-037 SHALL cover: correct BTN in round 1 -> NEXT, POINTS=2, ROUND=2, replay of 2 colors.
REQ-038 SHALL cover: wrong BTN, or BTN=4'b0011, in INPUT -> LOSE=1, STATE=7, POINTS unchanged; START -> new game with POINTS=0.
REQ-039 SHALL cover: no press for 20 TICKs -> LOSE; a BTN coincident with the 20th TICK -> press accepted, no timeout.
REQ-040 SHALL cover: MAX_ROUND=3, level=3, all presses correct -> WIN=1, ROUND=3, POINTS=9; SETUP_LEVEL=0 with START -> stays IDLE.
REQ-041 SHALL cover: RESET low during SHOW_ON -> next cycle STATE=0, LED=0, ROUND=0, POINTS=0.
